// File: rtl/johnson_decoder_monitor.sv
// Johnson-code receiver: checks legality, decodes to index/one-hot, and tracks
// forward-sequence health with a lock FSM and a saturating error counter.
module johnson_decoder_monitor #(
  parameter int WIDTH      = 4,
  parameter int LOCK_CNT   = 3,
  parameter int ERR_W      = 8,
  parameter int ALLOW_HOLD = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              count,
  output logic [$clog2(2*WIDTH)-1:0]    index,
  output logic [2*WIDTH-1:0]            onehot,
  output logic                          out_valid,
  output logic                          code_legal,
  output logic                          seq_err,
  output logic                          locked,
  output logic [ERR_W-1:0]              err_count
);

  localparam int N     = 2 * WIDTH;
  localparam int IDX_W = $clog2(N);
  localparam int GC_W  = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

  localparam logic [1:0] UNLOCKED = 2'd0;
  localparam logic [1:0] LOCKING  = 2'd1;
  localparam logic [1:0] LOCKED   = 2'd2;

  // A Johnson word has at most one boundary between its run of ones and zeros.
  function automatic logic is_legal(input logic [WIDTH-1:0] c);
    int d;
    d = 0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (c[i] != c[i+1]) d++;
    end
    return (d <= 1);
  endfunction

  function automatic logic [IDX_W-1:0] decode_idx(input logic [WIDTH-1:0] c);
    int k;
    k = 0;
    for (int i = 0; i < WIDTH; i++) begin
      k += int'(c[i]);
    end
    if (c[0]) return IDX_W'(N - k);
    else      return IDX_W'(k);
  endfunction

  function automatic logic [IDX_W-1:0] succ_idx(input logic [IDX_W-1:0] v);
    if (int'(v) == N - 1) return '0;
    else                  return v + IDX_W'(1);
  endfunction

  function automatic logic [N-1:0] onehot_of(input logic [IDX_W-1:0] v);
    logic [N-1:0] r;
    r    = '0;
    r[v] = 1'b1;
    return r;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    if (&v) return v;
    else    return v + ERR_W'(1);
  endfunction

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [GC_W-1:0]  good_cnt;
  logic [GC_W-1:0]  good_nx;
  logic [IDX_W-1:0] prev_idx;

  logic             legal_p0;
  logic [IDX_W-1:0] idx_p0;
  logic [IDX_W-1:0] exp_p0;
  logic             hold_p0;
  logic             good_p0;
  logic             bad_p0;
  logic             err_p0;

  // Stage p0: decode and classify the incoming sample against the reference.
  always_comb begin
    legal_p0 = is_legal(count);
    idx_p0   = decode_idx(count);
    exp_p0   = succ_idx(prev_idx);
    hold_p0  = legal_p0 && (ALLOW_HOLD != 0) && (idx_p0 == prev_idx);
    good_p0  = legal_p0 && !hold_p0 && (idx_p0 == exp_p0);
    bad_p0   = legal_p0 && !hold_p0 && !good_p0;

    state_nx = state;
    good_nx  = good_cnt;
    err_p0   = 1'b0;

    if (in_valid) begin
      case (state)
        UNLOCKED: begin
          if (legal_p0) begin
            state_nx = LOCKING;
            good_nx  = '0;
          end
        end
        LOCKING: begin
          if (!legal_p0) begin
            err_p0   = 1'b1;
            state_nx = UNLOCKED;
            good_nx  = '0;
          end else if (good_p0) begin
            if (int'(good_cnt) + 1 >= LOCK_CNT) begin
              state_nx = LOCKED;
              good_nx  = '0;
            end else begin
              good_nx = good_cnt + GC_W'(1);
            end
          end else if (bad_p0) begin
            err_p0  = 1'b1;
            good_nx = '0;
          end
        end
        LOCKED: begin
          if (!legal_p0) begin
            err_p0   = 1'b1;
            state_nx = UNLOCKED;
            good_nx  = '0;
          end else if (bad_p0) begin
            err_p0   = 1'b1;
            state_nx = LOCKING;
            good_nx  = '0;
          end
        end
        default: begin
          state_nx = UNLOCKED;
          good_nx  = '0;
        end
      endcase
    end
  end

  // Stage p1: registered outputs; an illegal code leaves the reference index untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= UNLOCKED;
      good_cnt   <= '0;
      prev_idx   <= '0;
      onehot     <= '0;
      out_valid  <= 1'b0;
      code_legal <= 1'b0;
      seq_err    <= 1'b0;
      locked     <= 1'b0;
      err_count  <= '0;
    end else begin
      state     <= state_nx;
      good_cnt  <= good_nx;
      out_valid <= in_valid;
      seq_err   <= err_p0;
      locked    <= (state_nx == LOCKED);
      if (in_valid) begin
        code_legal <= legal_p0;
        if (legal_p0) begin
          prev_idx <= idx_p0;
          onehot   <= onehot_of(idx_p0);
        end else begin
          onehot <= '0;
        end
        if (err_p0) err_count <= sat_inc(err_count);
      end
    end
  end

  assign index = prev_idx;

endmodule
